// File: rtl/par_product_cpa.sv
// Final carry-propagate adder for the Wallace tree multiplier.
// Resolves the sum/carry pair segment by segment in a stalled pipeline.
module par_product_cpa #(
   parameter int SUM_W       = 28,
   parameter int CARRY_W     = 25,
   parameter int CARRY_SHIFT = 3,
   parameter int SEG_W       = 7,
   parameter int TAG_W       = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SUM_W-1:0]   sum_in,
   input  logic [CARRY_W-1:0] carry_in,
   input  logic [TAG_W-1:0]   tag_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SUM_W-1:0]   result,
   output logic [TAG_W-1:0]   tag_out,
   output logic               busy
);

   localparam int NS = (SUM_W + SEG_W - 1) / SEG_W;

   logic             adv;
   logic [SUM_W-1:0] b_in;

   logic [SUM_W-1:0] a_q [NS-1];
   logic [SUM_W-1:0] b_q [NS-1];
   logic             c_q [NS-1];
   logic [SUM_W-1:0] r_q [NS];
   logic [TAG_W-1:0] t_q [NS];
   logic [NS-1:0]    v_q;

   logic [SUM_W-1:0] r_d [NS];
   logic             c_d [NS-1];

   assign adv       = !v_q[NS-1] || out_ready;
   assign in_ready  = adv;
   assign out_valid = v_q[NS-1];
   assign result    = r_q[NS-1];
   assign tag_out   = t_q[NS-1];
   assign busy      = |v_q;

   // Carry bits shifted to weight SUM_W or above fall off here.
   assign b_in = SUM_W'({carry_in, {CARRY_SHIFT{1'b0}}});

   for (genvar k = 0; k < NS; k++) begin : g_stg
      localparam int LO = k * SEG_W;
      localparam int W  = (k == NS - 1) ? SUM_W - LO : SEG_W;
      localparam int SW = (k == NS - 1) ? W : W + 1;

      logic [W-1:0]     a_seg;
      logic [W-1:0]     b_seg;
      logic             cin;
      logic [SUM_W-1:0] r_src;
      logic [SW-1:0]    s;
      logic [SUM_W-1:0] r_nxt;

      if (k == 0) begin : g_first
         assign a_seg = sum_in[LO +: W];
         assign b_seg = b_in[LO +: W];
         assign cin   = 1'b0;
         assign r_src = '0;
      end else begin : g_next
         assign a_seg = a_q[k-1][LO +: W];
         assign b_seg = b_q[k-1][LO +: W];
         assign cin   = c_q[k-1];
         assign r_src = r_q[k-1];
      end

      assign s = SW'(a_seg) + SW'(b_seg) + SW'(cin);

      always_comb begin
         r_nxt = r_src;
         r_nxt[LO +: W] = s[W-1:0];
      end

      assign r_d[k] = r_nxt;

      if (k < NS - 1) begin : g_co
         assign c_d[k] = s[SW-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= '0;
         for (int k = 0; k < NS; k++) begin
            r_q[k] <= '0;
            t_q[k] <= '0;
         end
         for (int k = 0; k < NS - 1; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            c_q[k] <= 1'b0;
         end
      end else if (adv) begin
         v_q <= {v_q[NS-2:0], in_valid};
         if (in_valid) begin
            r_q[0] <= r_d[0];
            t_q[0] <= tag_in;
            a_q[0] <= sum_in;
            b_q[0] <= b_in;
            c_q[0] <= c_d[0];
         end
         // Bubbles move like data but leave the stage payload untouched.
         for (int k = 1; k < NS; k++) begin
            if (v_q[k-1]) begin
               r_q[k] <= r_d[k];
               t_q[k] <= t_q[k-1];
            end
         end
         for (int k = 1; k < NS - 1; k++) begin
            if (v_q[k-1]) begin
               a_q[k] <= a_q[k-1];
               b_q[k] <= b_q[k-1];
               c_q[k] <= c_d[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_par_product_cpa.sv
// Scoreboard bench for par_product_cpa: random and directed streams
// checked against a plain-arithmetic reference model.
module tb_par_product_cpa;

   localparam int SUM_W   = 28;
   localparam int CARRY_W = 25;
   localparam int TAG_W   = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [SUM_W-1:0]   sum_in;
   logic [CARRY_W-1:0] carry_in;
   logic [TAG_W-1:0]   tag_in;
   logic               out_valid;
   logic               out_ready;
   logic [SUM_W-1:0]   result;
   logic [TAG_W-1:0]   tag_out;
   logic               busy;

   typedef struct packed {
      logic [SUM_W-1:0] res;
      logic [TAG_W-1:0] tag;
      int               cyc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   lat_chk  = 1'b0;

   par_product_cpa dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum_in    (sum_in),
      .carry_in  (carry_in),
      .tag_in    (tag_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .tag_out   (tag_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [SUM_W-1:0] model(
      input logic [SUM_W-1:0]   s,
      input logic [CARRY_W-1:0] c
   );
      longint unsigned t;
      t = longint'(s) + longint'(c) * 8;
      return SUM_W'(t % (64'd1 << SUM_W));
   endfunction

   task automatic check(input string name,
                        input logic [63:0] act,
                        input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic drive(input bit v,
                        input logic [SUM_W-1:0] s,
                        input logic [CARRY_W-1:0] c,
                        input logic [TAG_W-1:0] t,
                        input bit ordy,
                        output bit acc);
      exp_t e;
      @(negedge clk);
      in_valid  = v;
      sum_in    = s;
      carry_in  = c;
      tag_in    = t;
      out_ready = ordy;
      #1;
      acc = v && in_ready;
      if (acc) begin
         e.res = model(s, c);
         e.tag = t;
         e.cyc = cyc;
         sb.push_back(e);
      end
   endtask

   task automatic send(input logic [SUM_W-1:0] s,
                       input logic [CARRY_W-1:0] c,
                       input logic [TAG_W-1:0] t);
      bit acc;
      int n;
      n = 0;
      do begin
         drive(1'b1, s, c, t, 1'b1, acc);
         n++;
      end while (!acc && n < 50);
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=not accepted required=accepted");
      end
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++)
         drive(1'b0, '0, '0, '0, 1'b1, acc);
   endtask

   // Output monitor: pops the scoreboard on every output handshake.
   logic [SUM_W-1:0] held_r;
   logic [TAG_W-1:0] held_t;
   bit               held = 1'b0;

   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (rst) begin
         held = 1'b0;
      end else begin
         if (held && out_valid) begin
            check("stall_result", result, held_r);
            check("stall_tag", tag_out, held_t);
         end
         if (out_valid && !out_ready) begin
            check("in_ready_stall", in_ready, 0);
            check("busy_stall", busy, 1);
            held   = 1'b1;
            held_r = result;
            held_t = tag_out;
         end else begin
            held = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output actual=%0h required=no output",
                        result);
            end else begin
               e = sb.pop_front();
               check("result", result, e.res);
               check("tag", tag_out, e.tag);
               if (lat_chk) check("latency", cyc - e.cyc, 4);
            end
         end
      end
   end

   initial begin
      bit acc;
      int got;
      int guard;

      rst       = 1'b1;
      in_valid  = 1'b0;
      sum_in    = '0;
      carry_in  = '0;
      tag_in    = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_result", result, 0);
      check("rst_tag", tag_out, 0);

      lat_chk = 1'b1;
      send(28'h0000001, 25'h0000001, 3'd5);
      idle(6);

      send(28'hFFFFFF8, 25'h0000001, 3'd1);
      send(28'h0000000, 25'h1FFFFFF, 3'd2);
      idle(6);

      for (int i = 0; i < 8; i++)
         send(SUM_W'($urandom), CARRY_W'($urandom), TAG_W'(i));
      idle(6);
      lat_chk = 1'b0;

      for (int i = 0; i < 10; i++)
         drive(1'b1, SUM_W'($urandom), CARRY_W'($urandom),
               TAG_W'($urandom), 1'b1, acc);
      for (int i = 0; i < 6; i++)
         drive(1'b1, SUM_W'($urandom), CARRY_W'($urandom),
               TAG_W'($urandom), 1'b0, acc);
      for (int i = 0; i < 10; i++)
         drive(1'b1, SUM_W'($urandom), CARRY_W'($urandom),
               TAG_W'($urandom), 1'b1, acc);
      idle(8);
      check("drain_after_stall", sb.size(), 0);

      for (int i = 0; i < 3; i++)
         send(SUM_W'($urandom), CARRY_W'($urandom), TAG_W'(i));
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("flush_out_valid", out_valid, 0);
      check("flush_busy", busy, 0);
      check("flush_in_ready", in_ready, 1);
      check("flush_result", result, 0);
      idle(10);

      got   = 0;
      guard = 0;
      while (got < 10000 && guard < 60000) begin
         drive(($urandom % 4) != 0,
               ($urandom % 16 == 0) ? {SUM_W{1'b1}} : SUM_W'($urandom),
               ($urandom % 16 == 0) ? {CARRY_W{1'b1}} : CARRY_W'($urandom),
               TAG_W'($urandom), ($urandom % 4) != 0, acc);
         if (acc) got++;
         guard++;
      end
      check("random_accepted", got, 10000);

      guard = 0;
      while (sb.size() > 0 && guard < 200) begin
         drive(1'b0, '0, '0, '0, 1'b1, acc);
         guard++;
      end
      check("final_drain", sb.size(), 0);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
